// File: rtl/brush_painter.sv
// Square brush stamper and framebuffer clearer.
// Emits one clipped pixel write per accepted handshake.
module brush_painter #(
  parameter int RESOLUTION_H = 640,
  parameter int RESOLUTION_V = 480,
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int ADDR_WIDTH = 19,
  parameter int BRUSH_SIZE = 10,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  paint,
  input  logic                  clear,
  input  logic [HPOS_WIDTH-1:0] cursor_xpos,
  input  logic [VPOS_WIDTH-1:0] cursor_ypos,
  input  logic [2:0]            color,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [2:0]            wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int XW = HPOS_WIDTH + 1;
  localparam int YW = VPOS_WIDTH + 1;
  localparam logic [XW-1:0] XMAX = XW'(RESOLUTION_H - 1);
  localparam logic [YW-1:0] YMAX = YW'(RESOLUTION_V - 1);
  localparam logic [XW-1:0] BX = XW'(BRUSH_SIZE);
  localparam logic [YW-1:0] BY = YW'(BRUSH_SIZE);
  localparam logic [ADDR_WIDTH-1:0] H_STEP =
    ADDR_WIDTH'(RESOLUTION_H);

  typedef enum logic [1:0] {
    IDLE, SETUP, WRITE, DONE
  } state_t;

  state_t state;

  logic                  is_clear;
  logic [HPOS_WIDTH-1:0] cx;
  logic [VPOS_WIDTH-1:0] cy;
  logic [2:0]            col;
  logic [XW-1:0]         x, x_lo, x_hi;
  logic [YW-1:0]         y, y_hi;
  logic [ADDR_WIDTH-1:0] row_base;

  logic [XW-1:0]         cx_w, x_sum, xlo_n, xhi_n;
  logic [YW-1:0]         cy_w, y_sum, ylo_n, yhi_n;
  logic [ADDR_WIDTH-1:0] base_n;

  // Clipped stamp bounds, evaluated from the latched command.
  always_comb begin
    cx_w  = {1'b0, cx};
    cy_w  = {1'b0, cy};
    x_sum = cx_w + BX;
    y_sum = cy_w + BY;
    xlo_n = '0;
    xhi_n = XMAX;
    ylo_n = '0;
    yhi_n = YMAX;
    if (!is_clear) begin
      xlo_n = (cx_w < BX) ? '0 : cx_w - BX;
      xhi_n = (x_sum > XMAX) ? XMAX : x_sum;
      ylo_n = (cy_w < BY) ? '0 : cy_w - BY;
      yhi_n = (y_sum > YMAX) ? YMAX : y_sum;
    end
    base_n = ADDR_WIDTH'(ylo_n) * H_STEP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_clear <= 1'b0;
      cx       <= '0;
      cy       <= '0;
      col      <= '0;
      x        <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y        <= '0;
      y_hi     <= '0;
      row_base <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (paint || clear) begin
            is_clear <= clear;
            cx       <= cursor_xpos;
            cy       <= cursor_ypos;
            col      <= color;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          x        <= xlo_n;
          x_lo     <= xlo_n;
          x_hi     <= xhi_n;
          y        <= ylo_n;
          y_hi     <= yhi_n;
          row_base <= base_n;
          wr_addr  <= base_n + ADDR_WIDTH'(xlo_n);
          wr_data  <= is_clear ? CLEAR_COLOR : col;
          if (xlo_n > xhi_n || ylo_n > yhi_n) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wr_valid <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (x != x_hi) begin
              x       <= x + XW'(1);
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end else if (y != y_hi) begin
              x        <= x_lo;
              y        <= y + YW'(1);
              row_base <= row_base + H_STEP;
              wr_addr  <= row_base + H_STEP
                        + ADDR_WIDTH'(x_lo);
            end else begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brush_painter.sv
// Directed bench for brush_painter: stamps, clipping,
// back-pressure, clear and mid-operation reset.
module tb_brush_painter;

  logic        clk = 1'b0;
  logic        reset;
  logic        paint;
  logic        clear;
  logic [9:0]  cursor_xpos;
  logic [9:0]  cursor_ypos;
  logic [2:0]  color;
  logic        wr_valid;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  brush_painter dut (
    .clk(clk),
    .reset(reset),
    .paint(paint),
    .clear(clear),
    .cursor_xpos(cursor_xpos),
    .cursor_ypos(cursor_ypos),
    .color(color),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Issues one command at a negedge and follows it to done
  // or to the cycle limit; c==0 is the SETUP cycle.
  task automatic run_op(
    input  logic       p,
    input  logic       cl,
    input  int         xpos,
    input  int         ypos,
    input  logic [2:0] col,
    input  logic [2:0] exp_data,
    input  logic       toggle,
    input  logic       extra,
    input  int         limit,
    output int         cnt,
    output int         first,
    output int         last,
    output int         first_c,
    output int         last_c,
    output int         done_c,
    output int         stall_errs,
    output int         data_errs,
    output int         seq_errs
  );
    logic        hold;
    logic [18:0] prev_addr;
    logic [2:0]  prev_data;
    cnt = 0; first = -1; last = -1;
    first_c = -1; last_c = -1; done_c = -1;
    stall_errs = 0; data_errs = 0; seq_errs = 0;
    hold = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    cursor_xpos = 10'(xpos);
    cursor_ypos = 10'(ypos);
    color = col;
    paint = p;
    clear = cl;
    wr_ready = 1'b1;
    @(negedge clk);
    paint = 1'b0;
    clear = 1'b0;
    for (int c = 0; c < limit; c++) begin
      wr_ready = toggle ? c[0] : 1'b1;
      if (done) begin
        done_c = c;
        break;
      end
      if (hold && (!wr_valid || wr_addr !== prev_addr
                   || wr_data !== prev_data))
        stall_errs++;
      if (wr_valid && wr_ready) begin
        if (first < 0) begin
          first = int'(wr_addr);
          first_c = c;
        end
        if (wr_data !== exp_data) data_errs++;
        if (int'(wr_addr) != cnt) seq_errs++;
        last = int'(wr_addr);
        last_c = c;
        cnt++;
      end
      hold = wr_valid && !wr_ready;
      prev_addr = wr_addr;
      prev_data = wr_data;
      paint = extra && (c == 3);
      cursor_xpos = 10'd20;
      cursor_ypos = 10'd20;
      @(negedge clk);
    end
    paint = 1'b0;
  endtask

  int cnt, first, last, first_c, last_c, done_c;
  int stall_e, data_e, seq_e;

  initial begin
    reset = 1'b0;
    paint = 1'b0;
    clear = 1'b0;
    cursor_xpos = '0;
    cursor_ypos = '0;
    color = '0;
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(wr_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    reset = 1'b1;
    @(negedge clk);

    // Centre stamp, continuous ready.
    run_op(1, 0, 320, 240, 3'b101, 3'b101, 0, 0, 2000,
           cnt, first, last, first_c, last_c, done_c,
           stall_e, data_e, seq_e);
    check("c_count", 32'(cnt), 441);
    check("c_first", 32'(first), 147510);
    check("c_last", 32'(last), 160330);
    check("c_first_cycle", 32'(first_c), 1);
    check("c_done_cycle", 32'(done_c), 32'(last_c + 1));
    check("c_data", 32'(data_e), 0);
    @(negedge clk);
    check("c_done_width", 32'(done), 0);
    check("c_idle", 32'(busy), 0);

    // Top-left clipping.
    run_op(1, 0, 3, 2, 3'b010, 3'b010, 0, 0, 2000,
           cnt, first, last, first_c, last_c, done_c,
           stall_e, data_e, seq_e);
    check("tl_count", 32'(cnt), 182);
    check("tl_first", 32'(first), 0);
    check("tl_last", 32'(last), 7693);
    check("tl_done_cycle", 32'(done_c), 32'(last_c + 1));
    @(negedge clk);

    // Bottom-right clipping.
    run_op(1, 0, 639, 479, 3'b111, 3'b111, 0, 0, 2000,
           cnt, first, last, first_c, last_c, done_c,
           stall_e, data_e, seq_e);
    check("br_count", 32'(cnt), 121);
    check("br_first", 32'(first), 300789);
    check("br_last", 32'(last), 307199);
    check("br_data", 32'(data_e), 0);
    @(negedge clk);

    // Back-pressure with an ignored paint pulse mid-stamp.
    run_op(1, 0, 320, 240, 3'b011, 3'b011, 1, 1, 3000,
           cnt, first, last, first_c, last_c, done_c,
           stall_e, data_e, seq_e);
    check("bp_count", 32'(cnt), 441);
    check("bp_first", 32'(first), 147510);
    check("bp_last", 32'(last), 160330);
    check("bp_stall", 32'(stall_e), 0);
    check("bp_data", 32'(data_e), 0);
    check("bp_done_cycle", 32'(done_c), 32'(last_c + 1));
    repeat (3) @(negedge clk);
    check("bp_no_queue", 32'(busy), 0);

    // Fully off-screen stamp.
    run_op(1, 0, 700, 100, 3'b001, 3'b001, 0, 0, 20,
           cnt, first, last, first_c, last_c, done_c,
           stall_e, data_e, seq_e);
    check("off_count", 32'(cnt), 0);
    check("off_done_cycle", 32'(done_c), 1);
    @(negedge clk);

    // Clear beats paint; abandoned by reset mid-write.
    run_op(1, 1, 100, 100, 3'b111, 3'b000, 0, 0, 301,
           cnt, first, last, first_c, last_c, done_c,
           stall_e, data_e, seq_e);
    check("clr_count", 32'(cnt), 300);
    check("clr_first", 32'(first), 0);
    check("clr_last", 32'(last), 299);
    check("clr_seq", 32'(seq_e), 0);
    check("clr_data", 32'(data_e), 0);
    check("clr_busy", 32'(busy), 1);
    reset = 1'b0;
    paint = 1'b1;
    @(negedge clk);
    check("mr_valid", 32'(wr_valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_addr", 32'(wr_addr), 0);
    check("mr_data", 32'(wr_data), 0);
    @(negedge clk);
    check("mr_paint_ign", 32'(busy), 0);
    paint = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_stay_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
